// File: rtl/pc_ctrl.sv
// Fetch-stage sequencer: owns the program counter and instruction-ROM enable,
// and turns downstream stall/flush requests into the pipeline stall vector.
module pc_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          HOLD_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush_req,
  input  logic [31:0] exc_pc,
  output logic [31:0] pc,
  output logic        ce,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        misalign
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state;
  logic [3:0] hold_cnt;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    stall = 6'b000000;
    flush = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (flush_req)         flush = 1'b1;
          else if (stallreq_mem) stall = 6'b011111;
          else if (stallreq_ex)  stall = 6'b001111;
          else if (stallreq_id)  stall = 6'b000111;
        end
        FLUSH:   flush = flush_req;
        default: ;
      endcase
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HOLD;
      hold_cnt <= 4'd0;
      pc       <= RESET_VECTOR;
      ce       <= 1'b0;
      misalign <= 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          pc       <= RESET_VECTOR;
          misalign <= 1'b0;
          if (hold_cnt == HOLD_LAST) begin
            state    <= RUN;
            ce       <= 1'b1;
            hold_cnt <= 4'd0;
          end else begin
            ce       <= 1'b0;
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        RUN: begin
          ce <= 1'b1;
          if (flush_req) begin
            pc       <= {exc_pc[31:2], 2'b00};
            misalign <= |exc_pc[1:0];
            state    <= FLUSH;
          end else if (stall[0]) begin
            // Branch is dropped while stalled; ID re-presents it afterwards.
            misalign <= 1'b0;
          end else if (branch_flag) begin
            pc       <= {branch_target[31:2], 2'b00};
            misalign <= |branch_target[1:0];
          end else begin
            pc       <= pc + 32'd4;
            misalign <= 1'b0;
          end
        end
        FLUSH: begin
          ce <= 1'b1;
          if (flush_req) begin
            pc       <= {exc_pc[31:2], 2'b00};
            misalign <= |exc_pc[1:0];
          end else begin
            // Requests here come from squashed instructions and are ignored.
            pc       <= pc + 32'd4;
            misalign <= 1'b0;
            state    <= RUN;
          end
        end
        default: begin
          state <= HOLD;
          ce    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed-vector bench for pc_ctrl: hand-computed PC sequences, stall vectors,
// flush/redirect alignment, wrap-around and reset-during-stall.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        branch_flag, flush_req;
  logic [31:0] branch_target, exc_pc;
  logic [31:0] pc;
  logic        ce, flush, misalign;
  logic [5:0]  stall;

  int tests  = 0;
  int failed = 0;

  pc_ctrl #(.RESET_VECTOR(32'h0), .HOLD_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .flush_req(flush_req), .exc_pc(exc_pc),
    .pc(pc), .ce(ce), .stall(stall), .flush(flush), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    branch_flag = 0; flush_req = 0;
    branch_target = 32'h0; exc_pc = 32'h0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (3) tick();
    check("rst_pc", pc, 32'h0);
    check("rst_ce", 32'(ce), 32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);

    // Warm-up: ce low for two cycles, then fetch 0,4,8,C
    rst = 0;
    stallreq_mem = 1; flush_req = 1;
    #1;
    check("hold_stall_ignored", 32'(stall), 32'h0);
    check("hold_flush_ignored", 32'(flush), 32'h0);
    tick();
    check("hold_ce1", 32'(ce), 32'h0);
    check("hold_pc1", pc, 32'h0);
    idle_inputs();
    tick();
    check("first_ce", 32'(ce), 32'h1);
    check("first_pc", pc, 32'h0);
    tick(); check("seq_pc4", pc, 32'h4);
    tick(); check("seq_pc8", pc, 32'h8);
    tick(); check("seq_pcC", pc, 32'hC);
    tick(); check("seq_pc10", pc, 32'h10);

    // Branch 0x10 -> 0x100 -> 0x104
    branch_flag = 1; branch_target = 32'h100;
    #1;
    check("br_stall", 32'(stall), 32'h0);
    tick();
    check("br_pc", pc, 32'h100);
    check("br_misalign", 32'(misalign), 32'h0);
    idle_inputs();
    tick(); check("br_next", pc, 32'h104);

    // EX stall for 3 cycles at 0x20
    branch_flag = 1; branch_target = 32'h20;
    tick(); check("br_to_20", pc, 32'h20);
    idle_inputs();
    stallreq_ex = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ex_stall_vec", 32'(stall), 32'h0F);
      tick();
      check("ex_stall_pc", pc, 32'h20);
    end
    stallreq_ex = 0;
    tick(); check("ex_release_pc", pc, 32'h24);

    // Priority: id+mem -> mem vector; add flush_req -> flush only
    stallreq_id = 1; stallreq_mem = 1;
    #1;
    check("idmem_stall", 32'(stall), 32'h1F);
    check("idmem_flush", 32'(flush), 32'h0);
    flush_req = 1;
    #1;
    check("pri_flush", 32'(flush), 32'h1);
    check("pri_flush_stall", 32'(stall), 32'h0);

    // Misaligned exception redirect, stall request in FLUSH ignored
    stallreq_id = 0; stallreq_mem = 0; exc_pc = 32'h22;
    tick();
    check("exc_pc_aligned", pc, 32'h20);
    check("exc_misalign", 32'(misalign), 32'h1);
    flush_req = 0; stallreq_id = 1;
    #1;
    check("flushst_stall", 32'(stall), 32'h0);
    check("flushst_flush", 32'(flush), 32'h0);
    tick();
    check("after_flush_pc", pc, 32'h24);
    check("after_flush_mis", 32'(misalign), 32'h0);
    stallreq_id = 0;

    // Flush re-entered while in FLUSH
    flush_req = 1; exc_pc = 32'h40;
    tick(); check("reflush_pc1", pc, 32'h40);
    exc_pc = 32'h81;
    #1;
    check("reflush_flush", 32'(flush), 32'h1);
    tick();
    check("reflush_pc2", pc, 32'h80);
    check("reflush_mis", 32'(misalign), 32'h1);
    flush_req = 0;
    tick();
    check("reflush_exit", pc, 32'h84);
    check("reflush_mis0", 32'(misalign), 32'h0);

    // Misaligned branch near top, then wrap to 0
    branch_flag = 1; branch_target = 32'hFFFF_FFFD;
    tick();
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("top_mis", 32'(misalign), 32'h1);
    idle_inputs();
    tick();
    check("wrap_pc", pc, 32'h0);
    check("wrap_mis", 32'(misalign), 32'h0);
    tick(); check("wrap_next", pc, 32'h4);

    // Branch ignored under MEM stall, then reset mid-stall
    stallreq_mem = 1; branch_flag = 1; branch_target = 32'h200;
    tick(); check("stall_br_ignored", pc, 32'h4);
    rst = 1;
    #1;
    check("rst_comb_stall", 32'(stall), 32'h0);
    tick();
    check("midrst_pc", pc, 32'h0);
    check("midrst_ce", 32'(ce), 32'h0);
    check("midrst_stall", 32'(stall), 32'h0);
    rst = 0; idle_inputs();
    tick(); check("rerun_ce_low", 32'(ce), 32'h0);
    tick();
    check("rerun_ce", 32'(ce), 32'h1);
    check("rerun_pc", pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
